pr_master_arbiter: RTL and testbench

// - Sits between NUM_SLICES prefetcher control slices and the single DDR master AXI read port.
// - AR: round-robin arbitration of slice read requests into one registered AR output.
// - R: steers DDR read beats back to the owning slice via a per-slice learned-ID table.
// - Beats that match no slice are drained and counted so the DDR side never stalls.

---
 rtl/pr_master_arbiter.sv | 168 ++++++++++++++++
 tb/tb_pr_master_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_master_arbiter.sv
// pr_master_arbiter: round-robin AR arbiter for prefetcher slices
// plus ID-learned R beat steering with drain/drop counting.
module pr_master_arbiter #(
  parameter int NUM_SLICES      = 4,
  parameter int ADDR_BITS       = 64,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8,
  parameter int DATA_WIDTH      = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_SLICES-1:0]                 s_ar_valid,
  output logic [NUM_SLICES-1:0]                 s_ar_ready,
  input  logic [NUM_SLICES*ADDR_BITS-1:0]       s_ar_addr,
  input  logic [NUM_SLICES*BURST_LEN_WIDTH-1:0] s_ar_len,
  input  logic [NUM_SLICES*TID_WIDTH-1:0]       s_ar_id,
  input  logic [NUM_SLICES-1:0]                 slice_flush,
  output logic [NUM_SLICES-1:0]                 s_r_valid,
  input  logic [NUM_SLICES-1:0]                 s_r_ready,
  output logic [TID_WIDTH-1:0]                  s_r_id,
  output logic [DATA_WIDTH-1:0]                 s_r_data,
  output logic                                  m_ar_valid,
  input  logic                                  m_ar_ready,
  output logic [ADDR_BITS-1:0]                  m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]            m_ar_len,
  output logic [TID_WIDTH-1:0]                  m_ar_id,
  input  logic                                  m_r_valid,
  output logic                                  m_r_ready,
  input  logic [TID_WIDTH-1:0]                  m_r_id,
  input  logic [DATA_WIDTH-1:0]                 m_r_data,
  output logic [15:0]                           drop_cnt
);

  localparam int PW = $clog2(NUM_SLICES);

  logic                       ar_valid_q, ar_valid_d;
  logic [ADDR_BITS-1:0]       ar_addr_q, ar_addr_d;
  logic [BURST_LEN_WIDTH-1:0] ar_len_q, ar_len_d;
  logic [TID_WIDTH-1:0]       ar_id_q, ar_id_d;
  logic [PW-1:0]              rr_q, rr_d;
  logic [NUM_SLICES-1:0]      ent_v_q, ent_v_d;
  logic [TID_WIDTH-1:0]       ent_id_q [NUM_SLICES];
  logic [TID_WIDTH-1:0]       ent_id_d [NUM_SLICES];
  logic [15:0]                drop_q, drop_d;

  logic          can_load;
  logic          gnt_found;
  logic [PW-1:0] gnt_idx;
  logic [PW:0]   cand;
  logic          load;
  logic          own_found;
  logic [PW-1:0] own_idx;
  logic          drain;

  assign can_load = ~ar_valid_q | m_ar_ready;
  assign load     = can_load & gnt_found;

  // Pick the first requester at or after the RR pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_SLICES; k++) begin
      cand = (PW+1)'(rr_q) + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_SLICES))
        cand = cand - (PW+1)'(NUM_SLICES);
      if (!gnt_found && s_ar_valid[cand[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PW-1:0];
      end
    end
  end

  // Only the granted slice sees ready, and only when the AR register can load.
  always_comb begin
    s_ar_ready = '0;
    if (load)
      s_ar_ready[gnt_idx] = 1'b1;
  end

  // AR register, pointer and ID-table next state; a grant beats a flush.
  always_comb begin
    ar_valid_d = ar_valid_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_id_d    = ar_id_q;
    rr_d       = rr_q;
    ent_v_d    = ent_v_q;
    ent_id_d   = ent_id_q;
    if (m_ar_ready)
      ar_valid_d = 1'b0;
    if (load) begin
      ar_valid_d = 1'b1;
      ar_addr_d  = s_ar_addr[gnt_idx*ADDR_BITS +: ADDR_BITS];
      ar_len_d   = s_ar_len[gnt_idx*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
      ar_id_d    = s_ar_id[gnt_idx*TID_WIDTH +: TID_WIDTH];
      rr_d       = (gnt_idx == PW'(NUM_SLICES-1)) ? '0 : gnt_idx + 1'b1;
    end
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (load && gnt_idx == PW'(i)) begin
        ent_v_d[i]  = 1'b1;
        ent_id_d[i] = s_ar_id[i*TID_WIDTH +: TID_WIDTH];
      end else if (slice_flush[i]) begin
        ent_v_d[i] = 1'b0;
      end
    end
  end

  // Lowest-index slice whose learned ID matches the beat owns it.
  always_comb begin
    own_found = 1'b0;
    own_idx   = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (!own_found && ent_v_q[i] && ent_id_q[i] == m_r_id) begin
        own_found = 1'b1;
        own_idx   = PW'(i);
      end
    end
  end

  // Steer the beat to its owner, or drain it and count the drop.
  always_comb begin
    s_r_valid = '0;
    m_r_ready = 1'b1;
    if (own_found) begin
      s_r_valid[own_idx] = m_r_valid;
      m_r_ready          = s_r_ready[own_idx];
    end
    drain  = m_r_valid & ~own_found;
    drop_d = drop_q;
    if (drain && drop_q != 16'hFFFF)
      drop_d = drop_q + 16'd1;
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_id_q    <= '0;
      rr_q       <= '0;
      ent_v_q    <= '0;
      drop_q     <= '0;
      for (int i = 0; i < NUM_SLICES; i++)
        ent_id_q[i] <= '0;
    end else begin
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_id_q    <= ar_id_d;
      rr_q       <= rr_d;
      ent_v_q    <= ent_v_d;
      drop_q     <= drop_d;
      for (int i = 0; i < NUM_SLICES; i++)
        ent_id_q[i] <= ent_id_d[i];
    end
  end

  assign m_ar_valid = ar_valid_q;
  assign m_ar_addr  = ar_addr_q;
  assign m_ar_len   = ar_len_q;
  assign m_ar_id    = ar_id_q;
  assign s_r_id     = m_r_id;
  assign s_r_data   = m_r_data;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_pr_master_arbiter.sv
// tb_pr_master_arbiter: directed stimulus with AR and R
// scoreboards checked by an independent handshake monitor.
module tb_pr_master_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   s_ar_valid, s_ar_ready;
  logic [255:0] s_ar_addr;
  logic [31:0]  s_ar_len, s_ar_id;
  logic [3:0]   slice_flush, s_r_valid, s_r_ready;
  logic [7:0]   s_r_id;
  logic [63:0]  s_r_data;
  logic         m_ar_valid, m_ar_ready;
  logic [63:0]  m_ar_addr;
  logic [7:0]   m_ar_len, m_ar_id;
  logic         m_r_valid, m_r_ready;
  logic [7:0]   m_r_id;
  logic [63:0]  m_r_data;
  logic [15:0]  drop_cnt;

  always #5 clk = ~clk;

  pr_master_arbiter dut (
    .clk(clk), .reset(reset),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_id(s_ar_id),
    .slice_flush(slice_flush),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .s_r_id(s_r_id), .s_r_data(s_r_data),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .m_r_id(m_r_id), .m_r_data(m_r_data),
    .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [7:0]  id;
  } ar_t;

  typedef struct {
    logic [3:0]  sv;
    logic [7:0]  id;
    logic [63:0] data;
  } r_t;

  ar_t arq[$];
  r_t  rq[$];
  int  passed = 0;
  int  total  = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_slice(int i, logic [63:0] a, logic [7:0] l,
                           logic [7:0] id);
    s_ar_addr[i*64 +: 64] = a;
    s_ar_len[i*8 +: 8]    = l;
    s_ar_id[i*8 +: 8]     = id;
  endtask

  task automatic push_ar(logic [63:0] a, logic [7:0] l, logic [7:0] id);
    ar_t e;
    e.addr = a;
    e.len  = l;
    e.id   = id;
    arq.push_back(e);
  endtask

  task automatic push_r(logic [3:0] sv);
    r_t e;
    e.sv   = sv;
    e.id   = m_r_id;
    e.data = m_r_data;
    rq.push_back(e);
  endtask

  // Monitor: every completed handshake must match the next expectation.
  always @(negedge clk) begin
    ar_t ea;
    r_t  er;
    if (m_ar_valid && m_ar_ready) begin
      if (arq.size() == 0) begin
        total++;
        $display("FAIL ar_unexpected: got addr %0h expected none", m_ar_addr);
      end else begin
        ea = arq.pop_front();
        chk("ar_addr", m_ar_addr, ea.addr);
        chk("ar_len", 64'(m_ar_len), 64'(ea.len));
        chk("ar_id", 64'(m_ar_id), 64'(ea.id));
      end
    end
    if (m_r_valid && m_r_ready) begin
      if (rq.size() == 0) begin
        total++;
        $display("FAIL r_unexpected: got id %0h expected none", m_r_id);
      end else begin
        er = rq.pop_front();
        chk("r_svalid", 64'(s_r_valid), 64'(er.sv));
        chk("r_id", 64'(s_r_id), 64'(er.id));
        chk("r_data", s_r_data, er.data);
      end
    end
  end

  initial begin
    logic [3:0] oh;
    reset = 1'b1;
    s_ar_valid = '0; s_ar_addr = '0; s_ar_len = '0; s_ar_id = '0;
    slice_flush = '0; s_r_ready = '0; m_ar_ready = 1'b0;
    m_r_valid = 1'b0; m_r_id = '0; m_r_data = '0;
    repeat (2) step();
    sample();
    chk("rst_ar_valid", 64'(m_ar_valid), 64'd0);
    chk("rst_ar_addr", m_ar_addr, 64'd0);
    chk("rst_ar_len", 64'(m_ar_len), 64'd0);
    chk("rst_ar_id", 64'(m_ar_id), 64'd0);
    chk("rst_s_ar_ready", 64'(s_ar_ready), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_m_r_ready", 64'(m_r_ready), 64'd1);
    step();
    reset = 1'b0;

    // single request from slice 1
    set_slice(1, 64'h1000, 8'd3, 8'd5);
    s_ar_valid = 4'b0010;
    sample();
    chk("t1_ready", 64'(s_ar_ready), 64'b0010);
    push_ar(64'h1000, 8'd3, 8'd5);
    step();
    s_ar_valid = '0;
    sample();
    chk("t1_valid", 64'(m_ar_valid), 64'd1);
    chk("t1_addr", m_ar_addr, 64'h1000);
    chk("t1_len", 64'(m_ar_len), 64'd3);
    chk("t1_id", 64'(m_ar_id), 64'd5);
    step();
    m_ar_ready = 1'b1;
    sample();
    step();
    sample();
    chk("t1_drop_valid", 64'(m_ar_valid), 64'd0);

    // all slices requesting: 0,1,2,3,0 back to back
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    for (int i = 0; i < 4; i++)
      set_slice(i, 64'h100 * (i + 1), 8'(i), 8'(8'h10 + i));
    s_ar_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      sample();
      oh = 4'b0001 << (c % 4);
      chk("rr_grant", 64'(s_ar_ready), 64'(oh));
      if (c > 0) chk("rr_nobubble", 64'(m_ar_valid), 64'd1);
      push_ar(64'h100 * ((c % 4) + 1), 8'(c % 4), 8'(8'h10 + (c % 4)));
      step();
    end
    s_ar_valid = '0;
    sample();
    chk("rr_last_valid", 64'(m_ar_valid), 64'd1);
    step();
    sample();
    chk("rr_idle", 64'(m_ar_valid), 64'd0);

    // stall with slices 0 and 2 pending; pointer is at 1
    step();
    m_ar_ready = 1'b0;
    s_ar_valid = 4'b0101;
    sample();
    chk("st_grant2", 64'(s_ar_ready), 64'b0100);
    push_ar(64'h300, 8'd2, 8'h12);
    step();
    for (int c = 0; c < 5; c++) begin
      sample();
      chk("st_valid", 64'(m_ar_valid), 64'd1);
      chk("st_addr", m_ar_addr, 64'h300);
      chk("st_id", 64'(m_ar_id), 64'h12);
      chk("st_noready", 64'(s_ar_ready), 64'd0);
      step();
    end
    m_ar_ready = 1'b1;
    sample();
    chk("st_grant0", 64'(s_ar_ready), 64'b0001);
    push_ar(64'h100, 8'd0, 8'h10);
    step();
    sample();
    chk("st_grant2b", 64'(s_ar_ready), 64'b0100);
    push_ar(64'h300, 8'd2, 8'h12);
    step();
    s_ar_valid = '0;
    sample();
    step();
    sample();
    chk("st_idle", 64'(m_ar_valid), 64'd0);

    // learn IDs: slice0 id=2, slice3 id=7
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    set_slice(0, 64'h2000, 8'd1, 8'd2);
    set_slice(3, 64'h2300, 8'd1, 8'd7);
    s_ar_valid = 4'b1001;
    sample();
    chk("id_grant0", 64'(s_ar_ready), 64'b0001);
    push_ar(64'h2000, 8'd1, 8'd2);
    step();
    s_ar_valid = 4'b1000;
    sample();
    chk("id_grant3", 64'(s_ar_ready), 64'b1000);
    push_ar(64'h2300, 8'd1, 8'd7);
    step();
    s_ar_valid = '0;
    sample();
    step();

    // beat id=7 backpressured by slice 3
    m_r_valid = 1'b1; m_r_id = 8'd7; m_r_data = 64'hA5A5_0007;
    s_r_ready = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("bp_m_r_ready", 64'(m_r_ready), 64'd0);
      chk("bp_s_r_valid", 64'(s_r_valid), 64'b1000);
      step();
    end
    s_r_ready = 4'b1000;
    push_r(4'b1000);
    sample();
    step();
    m_r_id = 8'd2; m_r_data = 64'hA5A5_0002; s_r_ready = 4'b0001;
    push_r(4'b0001);
    sample();
    step();

    // unmatched beats drain
    m_r_id = 8'd9; s_r_ready = '0;
    for (int k = 0; k < 3; k++) begin
      m_r_data = 64'(k);
      push_r(4'b0000);
      sample();
      chk("drain_ready", 64'(m_r_ready), 64'd1);
      step();
    end
    m_r_valid = 1'b0;
    sample();
    chk("drop3", 64'(drop_cnt), 64'd3);

    // flush slice 0, then its old ID drains
    step();
    slice_flush = 4'b0001;
    step();
    slice_flush = '0;
    m_r_valid = 1'b1; m_r_id = 8'd2; s_r_ready = 4'hF;
    push_r(4'b0000);
    sample();
    step();
    m_r_valid = 1'b0;
    sample();
    chk("drop_flush", 64'(drop_cnt), 64'd4);

    // flush and grant on slice 0 in the same cycle
    step();
    set_slice(0, 64'h4000, 8'd2, 8'h22);
    s_ar_valid = 4'b0001; slice_flush = 4'b0001;
    push_ar(64'h4000, 8'd2, 8'h22);
    sample();
    step();
    s_ar_valid = '0; slice_flush = '0;
    sample();
    step();
    m_r_valid = 1'b1; m_r_id = 8'h22; m_r_data = 64'hBEEF;
    push_r(4'b0001);
    sample();
    step();
    m_r_valid = 1'b0;
    sample();
    chk("fg_nodrop", 64'(drop_cnt), 64'd4);

    // slice1 also learns id=7: lowest index wins
    step();
    set_slice(1, 64'h5000, 8'd0, 8'd7);
    s_ar_valid = 4'b0010;
    push_ar(64'h5000, 8'd0, 8'd7);
    sample();
    step();
    s_ar_valid = '0;
    sample();
    step();
    m_r_valid = 1'b1; m_r_id = 8'd7; m_r_data = 64'h7777;
    push_r(4'b0010);
    sample();
    step();
    m_r_valid = 1'b0;

    // saturation from 0xFFFE
    force dut.drop_q = 16'hFFFE;
    step();
    release dut.drop_q;
    sample();
    chk("sat_preload", 64'(drop_cnt), 64'hFFFE);
    step();
    m_r_valid = 1'b1; m_r_id = 8'd9;
    for (int k = 0; k < 3; k++) begin
      m_r_data = 64'(k + 16);
      push_r(4'b0000);
      sample();
      chk("sat_prog", 64'(drop_cnt), (k == 0) ? 64'hFFFE : 64'hFFFF);
      step();
    end
    m_r_valid = 1'b0;
    sample();
    chk("sat_final", 64'(drop_cnt), 64'hFFFF);

    // reset in the middle of a burst to slice 0
    step();
    m_r_valid = 1'b1; m_r_id = 8'h22; s_r_ready = 4'b0001;
    m_r_data = 64'hC0;
    push_r(4'b0001);
    sample();
    step();
    reset = 1'b1;
    m_r_data = 64'hC1;
    push_r(4'b0000);
    sample();
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    chk("mid_rst_svalid", 64'(s_r_valid), 64'd0);
    chk("mid_rst_ar", 64'(m_ar_valid), 64'd0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_r_data = 64'(8'hC2 + k);
      push_r(4'b0000);
      sample();
      step();
    end
    m_r_valid = 1'b0;
    sample();
    chk("mid_rst_drop2", 64'(drop_cnt), 64'd2);

    chk("ar_queue_empty", 64'(arq.size()), 64'd0);
    chk("r_queue_empty", 64'(rq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
